id_stage_ctrl: RTL and testbench
================================

// Module: id_stage_ctrl
// PURPOSE
// - Decode-stage controller: one-entry pipeline register between fetch (IF) and execute (EX).
// - Its instruction output drives the decoder and imm_gen.
// - Sequences the valid/ready handshake both ways.
// - Detects load-use hazards against EX and inserts bubbles.
// - Squashes its contents on a branch/jump redirect.
// - Keeps saturating stall and flush counters for performance debug.
// PARAMETERS
// - DATA_WIDTH   32  instruction/PC width; from my_pkg
// - REG_AW       5   register-index width
// - CNT_W        16  width of performance counters
// PORTS
// - clk          in   1           system clock, rising edge
// - rst          in   1           synchronous, active-high reset
// - if_valid     in   1           IF offers instruction
// - if_ready     out  1           ID can accept this cycle
// - if_inst      in   DATA_WIDTH  fetched instruction
// - if_pc        in   DATA_WIDTH  PC of fetched instruction
// - id_valid     out  1           ID holds an issuable instruction
// - ex_ready     in   1           EX accepts this cycle
// - id_inst      out  DATA_WIDTH  registered instruction (to decoder/imm_gen)
// - id_pc        out  DATA_WIDTH  registered PC
// - id_rs1       out  REG_AW      id_inst[19:15]
// - id_rs2       out  REG_AW      id_inst[24:20]
// - id_rd        out  REG_AW      id_inst[11:7]
// - ex_valid     in   1           EX holds a real instruction
// - ex_is_load   in   1           EX instruction is a LOAD
// - ex_rd        in   REG_AW      destination register of EX instruction
// - flush        in   1           redirect from EX; squash ID
// - hazard       out  1           load-use stall active this cycle
// - stall_cnt    out  CNT_W       hazard cycles, saturating
// - flush_cnt    out  CNT_W       flush events, saturating
// BEHAVIOUR
// - Reset values: full=0, id_inst=NOP (32'h0000_0013), id_pc=0, both counters 0.
// - Reset outputs: id_valid=0, if_ready=1, hazard=0.
// - States (from the full bit):
//   - EMPTY: full=0.
//   - FULL: full=1.
//   - STALL: FULL with hazard=1; an output condition, not a separate register.
// - Register use by opcode:
//   - 0110011, 0100011, 1100011 use rs1 and rs2.
//   - 0010011, 0000011, 1100111 use rs1 only.
//   - 0110111, 0010111, 1101111 and unknown opcodes use neither.
// - hazard = full & ex_valid & ex_is_load & ex_rd!=0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
// - id_valid = full & ~hazard & ~flush.
// - if_ready = ~full | (ex_ready & ~hazard) | flush.
// - Transfers:
//   - Accept: if_valid & if_ready & ~flush. Load if_inst/if_pc; full<=1. Latency 1 cycle.
//   - Issue: id_valid & ex_ready. full<=0 unless an accept happens in the same cycle.
//   - Simultaneous issue and accept: the register is overwritten, full stays 1. No bubble, so full throughput.
// - Stalls:
//   - Hazard holds the register; EX sees id_valid=0 (bubble).
//   - The next cycle EX holds the bubble, so the hazard clears. Exactly one bubble per load-use.
//   - ex_ready=0 with full=1 holds the register unchanged and deasserts if_ready.
// - Flush has priority over everything:
//   - full<=0 and id_inst<=NOP.
//   - Any if_valid in the flush cycle is consumed and dropped (wrong path).
// - Counters:
//   - stall_cnt +1 on every cycle with hazard=1.
//   - flush_cnt +1 on every flush cycle.
//   - Both saturate at all-ones with no wrap.
// - rst asserted mid-stream: all state returns to reset values at that edge; the in-flight instruction is lost.
// - Writes to x0 (ex_rd==0) never cause a hazard.
// STRUCTURE
// - my_pkg holds:
//   - DATA_WIDTH and REG_AW.
//   - Opcode constants OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC.
//   - NOP_INST = 32'h0000_0013.
//   - These are shared with imm_gen and the main decoder.
// - Sub-module reg_use_dec (combinational): opcode -> {use_rs1, use_rs2}.
// - Top level: pipeline register, handshake, hazard compare and counters.
// TESTING
// - Streaming:
//   - Stimulus: if_valid=1 and ex_ready=1 constant, instructions A,B,C.
//   - Required: id_valid high from cycle 1, A,B,C issued on consecutive cycles, if_ready stays 1.
// - Load-use:
//   - Stimulus: EX holds lw x5 (ex_is_load=1, ex_rd=5); ID holds add x6,x5,x7 (32'h00728333).
//   - Required: hazard=1 and id_valid=0 for one cycle, then issue; stall_cnt=1.
// - No false hazard:
//   - Case 1: ID holds lui x5 (32'h000122B7) with EX lw to x5. Required: hazard=0.
//   - Case 2: ID holds add x6,x0,x7 with EX lw x0 (ex_rd=0). Required: hazard=0.
// - Backpressure:
//   - Stimulus: ex_ready=0 for 3 cycles with full=1.
//   - Required: id_inst/id_pc stable, if_ready=0; issue on the cycle ex_ready returns to 1.
// - Flush:
//   - Stimulus: flush=1 while full, with if_valid=1 in the same cycle.
//   - Required: next cycle full=0, id_valid=0, id_inst=32'h00000013, flush_cnt=1; the incoming instruction is dropped.
// - Reset and saturation:
//   - Stimulus: rst pulse mid-stall. Required: all outputs at reset values next cycle.
//   - Stimulus: force 65536+ hazard cycles. Required: stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/my_pkg.sv
// Shared decode constants for the ID stage, the immediate generator and the main decoder.
package my_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_AW     = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
    } reg_use_t;

endpackage

// File: rtl/id_stage_ctrl_reg_use_dec.sv
// Combinational opcode classifier: which source registers an instruction actually reads.
module reg_use_dec
    import my_pkg::*;
(
    input  logic [6:0] opcode,
    output reg_use_t   reg_use
);

    // Decode source-register usage; unknown opcodes read nothing so they never stall.
    always_comb begin
        reg_use = '{use_rs1: 1'b0, use_rs2: 1'b0};
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: reg_use = '{use_rs1: 1'b1, use_rs2: 1'b1};
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: reg_use = '{use_rs1: 1'b1, use_rs2: 1'b0};
            OPC_LUI, OPC_AUIPC, OPC_JAL:   reg_use = '{use_rs1: 1'b0, use_rs2: 1'b0};
            default:                       reg_use = '{use_rs1: 1'b0, use_rs2: 1'b0};
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: one-entry IF->EX pipeline register with handshake,
// load-use bubble insertion, redirect squash and saturating performance counters.
module id_stage_ctrl #(
    parameter int DATA_WIDTH = my_pkg::DATA_WIDTH,
    parameter int REG_AW     = my_pkg::REG_AW,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [DATA_WIDTH-1:0] if_inst,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  id_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [REG_AW-1:0]     id_rs1,
    output logic [REG_AW-1:0]     id_rs2,
    output logic [REG_AW-1:0]     id_rd,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_AW-1:0]     ex_rd,
    input  logic                  flush,
    output logic                  hazard,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(my_pkg::NOP_INST);

    logic             full;
    my_pkg::reg_use_t reg_use;
    logic             accept;
    logic             issue;
    logic             rs1_hit;
    logic             rs2_hit;

    reg_use_dec u_reg_use_dec (
        .opcode  (id_inst[6:0]),
        .reg_use (reg_use)
    );

    assign id_rs1 = id_inst[19:15];
    assign id_rs2 = id_inst[24:20];
    assign id_rd  = id_inst[11:7];

    // Load-use compare against EX; a load to x0 never produces data, so it is ignored.
    always_comb begin
        rs1_hit  = reg_use.use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = reg_use.use_rs2 && (id_rs2 == ex_rd);
        hazard   = full && ex_valid && ex_is_load && (ex_rd != {REG_AW{1'b0}}) && (rs1_hit || rs2_hit);
        id_valid = full && !hazard && !flush;
        if_ready = !full || (ex_ready && !hazard) || flush;
        accept   = if_valid && if_ready && !flush;
        issue    = id_valid && ex_ready;
    end

    // Pipeline register: flush beats accept beats issue; accept+issue overwrites in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 1'b0;
            id_inst <= NOP;
            id_pc   <= {DATA_WIDTH{1'b0}};
        end else if (flush) begin
            full    <= 1'b0;
            id_inst <= NOP;
        end else if (accept) begin
            full    <= 1'b1;
            id_inst <= if_inst;
            id_pc   <= if_pc;
        end else if (issue) begin
            full    <= 1'b0;
        end else begin
            full    <= full;
        end
    end

    // Saturating debug counters: stop at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed self-checking bench for id_stage_ctrl.
module tb_id_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        ex_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        hazard;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] INST_A   = 32'h0010_0093;
    localparam logic [31:0] INST_B   = 32'h0020_0113;
    localparam logic [31:0] INST_C   = 32'h0030_0193;
    localparam logic [31:0] ADD_X5   = 32'h0072_8333;
    localparam logic [31:0] LUI_X5   = 32'h0001_22B7;
    localparam logic [31:0] ADD_X0   = 32'h0070_0333;
    localparam logic [31:0] NOP_I    = 32'h0000_0013;

    always #5 clk = ~clk;

    id_stage_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .id_valid   (id_valid),
        .ex_ready   (ex_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .hazard     (hazard),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid   = 1'b0;
        if_inst    = 32'h0;
        if_pc      = 32'h0;
        ex_ready   = 1'b1;
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        flush      = 1'b0;
    endtask

    // Loads one instruction into an empty ID register and leaves inputs idle.
    task automatic load_id(input logic [31:0] inst, input logic [31:0] pc);
        idle_inputs();
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
        total++; if (id_inst !== NOP_I) begin bad++; $display("FAIL reset_id_inst got=%h exp=%h", id_inst, NOP_I); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        total++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_streaming();
        logic [31:0] insts [3];
        insts[0] = INST_A; insts[1] = INST_B; insts[2] = INST_C;
        idle_inputs();
        if_valid = 1'b1;
        if_inst  = insts[0];
        if_pc    = 32'h100;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stream_c0_valid got=%b exp=0", id_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) begin
                if_inst = insts[i+1];
                if_pc   = 32'h100 + 32'(4 * (i + 1));
            end else begin
                if_valid = 1'b0;
            end
            #1;
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, id_valid); end
            total++; if (id_inst !== insts[i]) begin bad++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, id_inst, insts[i]); end
            total++; if (id_pc !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, id_pc, 32'h100 + 32'(4 * i)); end
            total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL stream_if_ready[%0d] got=%b exp=1", i, if_ready); end
        end
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", id_valid); end
    endtask

    task automatic test_load_use();
        load_id(ADD_X5, 32'h200);
        total++; if (id_rs1 !== 5'd5 || id_rs2 !== 5'd7 || id_rd !== 5'd6) begin bad++; $display("FAIL fields got=%0d/%0d/%0d exp=5/7/6", id_rs1, id_rs2, id_rd); end
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL lu_hazard got=%b exp=1", hazard); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", id_valid); end
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL lu_if_ready got=%b exp=0", if_ready); end
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
        #1;
        total++; if (hazard !== 1'b0 || id_valid !== 1'b1) begin bad++; $display("FAIL lu_release got=%b/%b exp=0/1", hazard, id_valid); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL lu_issued got=%b exp=0", id_valid); end
    endtask

    task automatic test_no_false_hazard();
        load_id(LUI_X5, 32'h300);
        ex_ready = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL nfh_lui got=%b exp=0", hazard); end
        ex_valid = 1'b0; ex_ready = 1'b1;
        tick();
        load_id(ADD_X0, 32'h304);
        ex_ready = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0;
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL nfh_x0 got=%b exp=0", hazard); end
        ex_rd = 5'd7;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL nfh_rs2_hit got=%b exp=1", hazard); end
        ex_is_load = 1'b0;
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL nfh_not_load got=%b exp=0", hazard); end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        load_id(INST_A, 32'h400);
        ex_ready = 1'b0;
        if_valid = 1'b1; if_inst = INST_B; if_pc = 32'h404;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (id_inst !== INST_A || id_pc !== 32'h400) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%h exp=%h/400", i, id_inst, id_pc, INST_A); end
            total++; if (if_ready !== 1'b0 || id_valid !== 1'b1) begin bad++; $display("FAIL bp_hs[%0d] got=%b/%b exp=0/1", i, if_ready, id_valid); end
            tick();
        end
        ex_ready = 1'b1;
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b exp=1", if_ready); end
        tick();
        if_valid = 1'b0;
        #1;
        total++; if (id_inst !== INST_B || id_valid !== 1'b1) begin bad++; $display("FAIL bp_next got=%h/%b exp=%h/1", id_inst, id_valid, INST_B); end
        tick();
    endtask

    task automatic test_flush();
        load_id(INST_C, 32'h500);
        flush = 1'b1;
        if_valid = 1'b1; if_inst = INST_A; if_pc = 32'h504;
        #1;
        total++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin bad++; $display("FAIL fl_cycle got=%b/%b exp=0/1", id_valid, if_ready); end
        tick();
        idle_inputs();
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", id_valid); end
        total++; if (id_inst !== NOP_I) begin bad++; $display("FAIL fl_inst got=%h exp=%h", id_inst, NOP_I); end
        total++; if (flush_cnt !== 16'd1) begin bad++; $display("FAIL fl_cnt got=%0d exp=1", flush_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        load_id(ADD_X5, 32'h600);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0 || hazard !== 1'b0 || if_ready !== 1'b1) begin bad++; $display("FAIL rst_hs got=%b/%b/%b exp=0/0/1", id_valid, hazard, if_ready); end
        total++; if (id_inst !== NOP_I || id_pc !== 32'h0) begin bad++; $display("FAIL rst_reg got=%h/%h exp=%h/0", id_inst, id_pc, NOP_I); end
        total++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        load_id(ADD_X5, 32'h700);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        repeat (65534) @(posedge clk);
        #1;
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sat_hazard got=%b exp=1", hazard); end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_load_use();
        test_no_false_hazard();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
